// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the 4-way channel fabric (mux4way_arbiter,
// dmux4way). Holds the channel count, the 2-bit source select encoding used
// to tag beats, and the pointer advance helper.
package mux_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // Channel after idx, wrapping d back to a (2-bit arithmetic wraps naturally).
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way request picker.
// Ports:
//   req[3:0]       request per channel (bit0=a .. bit3=d)
//   ptr[1:0]       channel with highest priority; priority then wraps d->a
//   grant_idx[1:0] first requesting channel at or after ptr (SEL_A if none)
//   any            at least one request is present
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [1:0]        grant_idx,
  output logic              any
);

  // Walk offsets 0..3 from ptr; the first requesting channel wins.
  always_comb begin
    logic [1:0] idx_s;
    logic       found_s;
    grant_idx = SEL_A;
    found_s   = 1'b0;
    idx_s     = 2'b00;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = ptr + k[1:0];
      if (!found_s && req[idx_s]) begin
        grant_idx = idx_s;
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux4way_arbiter.sv
// mux4way_arbiter: four valid/ready input channels merged into one registered
// output beat tagged with its source select (a=00, b=01, c=10, d=11).
// Build option: MUX4WAY_ARBITER_RR_EN selects round-robin arbitration with a
// rotating pointer; without it priority is fixed a>b>c>d and no pointer exists.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid[3:0]         per-channel valid
//   in_data[4*WIDTH-1:0]  channel i at [i*WIDTH +: WIDTH]
//   in_ready[3:0]         one-hot (or zero) grant, combinational
//   out_valid/out_data/out_sel  registered output beat
//   out_ready             downstream accepts the beat
module mux4way_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_sel,
  input  logic                    out_ready
);

  logic              can_accept_s;
  logic              xfer_s;
  logic              any_s;
  logic [1:0]        grant_s;
  logic [1:0]        ptr_s;
  logic [NUM_CH-1:0] ready_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [1:0]        out_sel_r;

`ifdef MUX4WAY_ARBITER_RR_EN
  logic [1:0] ptr_r;

  // Priority pointer: moves to just past the channel that was served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= SEL_A;
    end else if (xfer_s) begin
      ptr_r <= next_ptr(grant_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = SEL_A;
`endif

  rr_pick4 u_pick (
    .req       (in_valid),
    .ptr       (ptr_s),
    .grant_idx (grant_s),
    .any       (any_s)
  );

  // Handshake: grant only when the output slot is free or draining this cycle.
  // Reset is folded in so no channel sees ready while the block is held.
  always_comb begin
    can_accept_s = !out_valid_r || out_ready;
    xfer_s       = !reset && can_accept_s && any_s;
    ready_s      = 4'b0000;
    if (xfer_s) begin
      ready_s = 4'b0001 << grant_s;
    end else begin
      ready_s = 4'b0000;
    end
  end

  // Data of the granted channel.
  always_comb begin
    sel_data_s = '0;
    case (grant_s)
      SEL_A:   sel_data_s = in_data[0*WIDTH +: WIDTH];
      SEL_B:   sel_data_s = in_data[1*WIDTH +: WIDTH];
      SEL_C:   sel_data_s = in_data[2*WIDTH +: WIDTH];
      SEL_D:   sel_data_s = in_data[3*WIDTH +: WIDTH];
      default: sel_data_s = '0;
    endcase
  end

  // Output register: load on transfer, clear valid on drain, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= SEL_A;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_sel_r   <= grant_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule
